// File: rtl/sample_mem_pkg.sv
// Shared definitions for the sample memory scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default address/data widths and the scheduler state enum.
package sample_mem_pkg;

  localparam int ADDR_BITS_DEF = 8;
  localparam int DATA_BITS_DEF = 32;

  // CLEAR sweeps zeros through the whole array; RUN serves requests.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } sched_state_e;

endpackage

// File: rtl/sample_mem_array.sv
// Single-port-write, single-port-read storage with a registered read.
// Latency: read data valid one cycle after rd_en; reads return pre-write data.
// Backpressure: none, always accepts.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request;
//        rd_data registered read data (holds when rd_en is low).
module sample_mem_array
  import sample_mem_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // No reset on purpose: contents are defined by the scheduler's clear sweep.
  // Both accesses in one block so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_mem_sched.sv
// Round-robin multi-writer / single-reader memory scheduler with a clear sweep.
// Latency: write commits on the grant edge; read response one cycle after accept.
// Backpressure: all ready outputs low during the clear sweep; one writer per cycle.
// Ports: clk, reset (async, active-high); wr_valid/wr_addr/wr_data/wr_ready per
//        requester; rd_valid/rd_addr/rd_ready; rsp_valid/rsp_data; clr_req; init_done.
module sample_mem_sched
  import sample_mem_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           wr_valid,
  input  logic [NREQ*ADDR_BITS-1:0] wr_addr,
  input  logic [NREQ*DATA_BITS-1:0] wr_data,
  output logic [NREQ-1:0]           wr_ready,
  input  logic                      rd_valid,
  input  logic [ADDR_BITS-1:0]      rd_addr,
  output logic                      rd_ready,
  output logic                      rsp_valid,
  output logic [DATA_BITS-1:0]      rsp_data,
  input  logic                      clr_req,
  output logic                      init_done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e         state;
  logic [ADDR_BITS-1:0] clr_cnt;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     rr_next;
  logic [NREQ-1:0]      grant;
  logic                 gnt_any;
  logic                 rd_fire;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [DATA_BITS-1:0] mem_wd;
  logic [DATA_BITS-1:0] mem_q;
  logic [DATA_BITS-1:0] rsp_hold;

  logic [ADDR_BITS-1:0] req_addr [NREQ];
  logic [DATA_BITS-1:0] req_data [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_addr[i] = wr_addr[i*ADDR_BITS +: ADDR_BITS];
    assign req_data[i] = wr_data[i*DATA_BITS +: DATA_BITS];
  end

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    int               pos;
    logic [PTR_W-1:0] cand;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = 0;
    cand    = '0;
    if (state == RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        pos = int'(rr_ptr) + k;
        if (pos >= NREQ) begin
          pos = pos - NREQ;
        end
        cand = PTR_W'(pos);
        if (!gnt_any && wr_valid[cand]) begin
          gnt_any     = 1'b1;
          gnt_idx     = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  assign rr_next  = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  assign wr_ready = grant;
  assign rd_ready = (state == RUN);
  assign rd_fire  = rd_valid && rd_ready;

  // The sweep owns the write port in CLEAR; the granted requester owns it in RUN.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_cnt;
    mem_wd = '0;
    if (state == CLEAR) begin
      mem_we = 1'b1;
    end else if (gnt_any) begin
      mem_we = 1'b1;
      mem_wa = req_addr[gnt_idx];
      mem_wd = req_data[gnt_idx];
    end
  end

  sample_mem_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_wa),
    .wr_data (mem_wd),
    .rd_en   (rd_fire),
    .rd_addr (rd_addr),
    .rd_data (mem_q)
  );

  // The array's read register has no reset, so the visible data comes from a
  // resettable copy except in the cycle a fresh response lands.
  assign rsp_data = rsp_valid ? mem_q : rsp_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_hold  <= '0;
      init_done <= 1'b0;
    end else begin
      rsp_valid <= rd_fire;
      if (rsp_valid) begin
        rsp_hold <= mem_q;
      end
      if (gnt_any) begin
        rr_ptr <= rr_next;
      end
      case (state)
        CLEAR: begin
          // Counter wraps back to 0 on the final address, ready for the next sweep.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          // This cycle's accepted read/write still complete via the logic above.
          if (clr_req) begin
            state     <= CLEAR;
            init_done <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_mem_sched.sv
module tb_sample_mem_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  wr_valid = '0;
  logic [15:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [1:0]  wr_ready;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic        rd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        clr_req = 1'b0;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  sample_mem_sched #(.NREQ(2), .ADDR_BITS(8), .DATA_BITS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .clr_req   (clr_req),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int r, input logic [7:0] a, input logic [31:0] d);
    wr_addr[r*8 +: 8]   = a;
    wr_data[r*32 +: 32] = d;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic do_read(input logic [7:0] a, output logic v, output logic [31:0] d);
    rd_valid = 1'b1;
    rd_addr  = a;
    step();
    rd_valid = 1'b0;
    v = rsp_valid;
    d = rsp_data;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) step();
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    wr_valid = 2'b11;
    #1;
    checks++; if (wr_ready !== 2'b00) begin errors++; $display("FAIL reset_wr_ready: got %b want 00", wr_ready); end
    wr_valid = 2'b00;
    reset = 1'b0;
    wait_init(n);
    checks++; if (n !== 256) begin errors++; $display("FAIL init_latency: got %0d want 256", n); end
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL init_rd_ready: got %b want 1", rd_ready); end
  endtask

  task automatic test_init_reads();
    logic [7:0]  addrs [3] = '{8'd0, 8'd127, 8'd255};
    logic        v;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], v, d);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL init_read_vld addr %0d: got %b want 1", addrs[i], v); end
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL init_read_dat addr %0d: got %h want 0", addrs[i], d); end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic        v;
    logic [31:0] d;
    set_wr(0, 8'd5, 32'hA);
    set_wr(1, 8'd5, 32'hB);
    wr_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (wr_ready !== exp_g[i]) begin errors++; $display("FAIL rr_grant %0d: got %b want %b", i, wr_ready, exp_g[i]); end
      step();
    end
    wr_valid = 2'b00;
    do_read(8'd5, v, d);
    checks++; if (d !== 32'hB) begin errors++; $display("FAIL rr_final_data: got %h want 0000000b", d); end
  endtask

  task automatic test_single_req();
    logic        v;
    logic [31:0] d;
    set_wr(1, 8'd20, 32'h77);
    wr_valid = 2'b10;
    #1;
    checks++; if (wr_ready !== 2'b10) begin errors++; $display("FAIL single_grant: got %b want 10", wr_ready); end
    step();
    set_wr(0, 8'd21, 32'h55);
    wr_valid = 2'b11;
    #1;
    checks++; if (wr_ready !== 2'b01) begin errors++; $display("FAIL single_ptr_wrap: got %b want 01", wr_ready); end
    step();
    wr_valid = 2'b00;
    step();
    set_wr(1, 8'd22, 32'h66);
    wr_valid = 2'b11;
    #1;
    checks++; if (wr_ready !== 2'b10) begin errors++; $display("FAIL ptr_hold_idle: got %b want 10", wr_ready); end
    step();
    wr_valid = 2'b00;
    #1;
    checks++; if (wr_ready !== 2'b00) begin errors++; $display("FAIL no_valid_grant: got %b want 00", wr_ready); end
    do_read(8'd20, v, d);
    checks++; if (d !== 32'h77) begin errors++; $display("FAIL single_rd20: got %h want 00000077", d); end
    do_read(8'd21, v, d);
    checks++; if (d !== 32'h55) begin errors++; $display("FAIL single_rd21: got %h want 00000055", d); end
    do_read(8'd22, v, d);
    checks++; if (d !== 32'h66) begin errors++; $display("FAIL single_rd22: got %h want 00000066", d); end
  endtask

  task automatic test_same_cycle();
    logic        v;
    logic [31:0] d;
    set_wr(0, 8'd127, 32'h1234);
    wr_valid = 2'b01;
    rd_valid = 1'b1;
    rd_addr  = 8'd127;
    step();
    wr_valid = 2'b00;
    rd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rfw_vld: got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rfw_old_data: got %h want 0", rsp_data); end
    do_read(8'd127, v, d);
    checks++; if (d !== 32'h1234) begin errors++; $display("FAIL rfw_new_data: got %h want 00001234", d); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp_vld: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h1234) begin errors++; $display("FAIL rsp_hold: got %h want 00001234", rsp_data); end
  endtask

  task automatic test_clear_req();
    int          n;
    logic        v;
    logic [31:0] d;
    set_wr(1, 8'd9, 32'hFFFF_FFFF);
    wr_valid = 2'b10;
    rd_valid = 1'b1;
    rd_addr  = 8'd9;
    clr_req  = 1'b1;
    #1;
    checks++; if (wr_ready !== 2'b10) begin errors++; $display("FAIL clr_cycle_grant: got %b want 10", wr_ready); end
    step();
    wr_valid = 2'b00;
    rd_valid = 1'b0;
    clr_req  = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL clr_cycle_rsp_vld: got %b want 1", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL clr_cycle_rsp_dat: got %h want 0", rsp_data); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL clr_init_done: got %b want 0", init_done); end
    n = 0;
    while (rd_ready === 1'b0 && n < 400) begin
      if (n == 5) begin
        wr_valid = 2'b11;
        #1;
        checks++; if (wr_ready !== 2'b00) begin errors++; $display("FAIL clr_wr_ready: got %b want 00", wr_ready); end
        wr_valid = 2'b00;
      end
      if (n == 10) clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      n++;
    end
    checks++; if (n !== 256) begin errors++; $display("FAIL clr_ready_low_cycles: got %0d want 256", n); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL clr_init_done_after: got %b want 1", init_done); end
    do_read(8'd9, v, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_rd9: got %h want 0", d); end
    do_read(8'd20, v, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_rd20: got %h want 0", d); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    rd_valid = 1'b1;
    rd_addr  = 8'd9;
    reset    = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_run_rsp_vld: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_run_rsp_dat: got %h want 0", rsp_data); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL rst_run_rd_ready: got %b want 0", rd_ready); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_run_no_rsp: got %b want 0", rsp_valid); end
    rd_valid = 1'b0;
    step();
    reset = 1'b0;
    wait_init(n);
    checks++; if (n !== 256) begin errors++; $display("FAIL rst_run_reinit: got %0d want 256", n); end
  endtask

  task automatic test_reset_mid_clear();
    int          n;
    logic        v;
    logic [31:0] d;
    set_wr(0, 8'd200, 32'hCAFE);
    wr_valid = 2'b01;
    step();
    wr_valid = 2'b00;
    clr_req  = 1'b1;
    step();
    clr_req  = 1'b0;
    repeat (100) step();
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_clear_init_done: got %b want 0", init_done); end
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    wait_init(n);
    checks++; if (n !== 256) begin errors++; $display("FAIL mid_clear_restart: got %0d want 256", n); end
    wr_valid = 2'b11;
    #1;
    checks++; if (wr_ready !== 2'b01) begin errors++; $display("FAIL rr_ptr_reset: got %b want 01", wr_ready); end
    wr_valid = 2'b00;
    do_read(8'd200, v, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_clear_rd200: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_init_reads();
    test_round_robin();
    test_single_req();
    test_same_cycle();
    test_clear_req();
    test_reset_mid_run();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
